// File: rtl/life_next_gen.sv
// life_next_gen: serial Game of Life generation engine for a 16x16 board.
// A step request walks every cell once (one per clock), writing the next
// generation into a shadow register. The shadow is copied into the visible
// board only while vblank is high, so the display never sees a torn frame.
// A seed load overwrites both registers and aborts any generation in flight.
//
// Optional feature macro: LIFE_TORUS_EN
//   defined   - board edges wrap (toroidal grid)
//   undefined - neighbours outside the grid count as dead
module life_next_gen #(
    parameter int ROW_SIZE = 16,
    parameter int COL_SIZE = 16,
    parameter int GEN_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         step,
    input  logic                         vblank,
    input  logic                         load,
    input  logic [ROW_SIZE*COL_SIZE-1:0] seed,
    output logic [ROW_SIZE*COL_SIZE-1:0] board,
    output logic                         busy,
    output logic                         gen_done,
    output logic [GEN_W-1:0]             gen_count
);

    localparam int CELLS = ROW_SIZE * COL_SIZE;
    localparam int IDX_W = $clog2(CELLS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALC    = 2'd1,
        WAIT_VB = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CELLS-1:0] shadow;
    logic [IDX_W-1:0] idx;
    logic [3:0]       n_live;
    logic             next_cell;
    logic             last_cell;
    logic             commit;

    // Live-neighbour count of cell (row, col), always read from the visible board.
    function automatic logic [3:0] count_neighbours(
        input logic [CELLS-1:0] b,
        input int               row,
        input int               col
    );
        logic [3:0] n;
        int         r;
        int         c;
        n = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (!(dr == 0 && dc == 0)) begin
                    r = row + dr;
                    c = col + dc;
`ifdef LIFE_TORUS_EN
                    r = (r < 0) ? r + COL_SIZE : ((r >= COL_SIZE) ? r - COL_SIZE : r);
                    c = (c < 0) ? c + ROW_SIZE : ((c >= ROW_SIZE) ? c - ROW_SIZE : c);
                    n = n + {3'd0, b[IDX_W'(r * ROW_SIZE + c)]};
`else
                    if (r >= 0 && r < COL_SIZE && c >= 0 && c < ROW_SIZE) begin
                        n = n + {3'd0, b[IDX_W'(r * ROW_SIZE + c)]};
                    end
`endif
                end
            end
        end
        return n;
    endfunction

    // Next-generation value of the cell currently addressed by idx (B3/S23).
    always_comb begin
        n_live    = count_neighbours(board, int'(idx) / ROW_SIZE, int'(idx) % ROW_SIZE);
        next_cell = (n_live == 4'd3) | (board[idx] & (n_live == 4'd2));
        last_cell = (idx == IDX_W'(CELLS - 1));
        commit    = (state == WAIT_VB) && vblank && !load;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: load always returns to IDLE, step only starts from IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!load && step) begin
                    next_state = CALC;
                end else begin
                    next_state = IDLE;
                end
            end
            CALC: begin
                if (load) begin
                    next_state = IDLE;
                end else if (last_cell) begin
                    next_state = WAIT_VB;
                end else begin
                    next_state = CALC;
                end
            end
            WAIT_VB: begin
                if (load || vblank) begin
                    next_state = IDLE;
                end else begin
                    next_state = WAIT_VB;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: seed load, serial cell evaluation and blanking-time commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board     <= {CELLS{1'b0}};
            shadow    <= {CELLS{1'b0}};
            idx       <= {IDX_W{1'b0}};
            busy      <= 1'b0;
            gen_done  <= 1'b0;
            gen_count <= {GEN_W{1'b0}};
        end else begin
            gen_done <= 1'b0;
            if (load) begin
                board     <= seed;
                shadow    <= seed;
                gen_count <= {GEN_W{1'b0}};
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (step) begin
                            idx  <= {IDX_W{1'b0}};
                            busy <= 1'b1;
                        end
                    end
                    CALC: begin
                        shadow[idx] <= next_cell;
                        idx         <= idx + IDX_W'(1);
                    end
                    WAIT_VB: begin
                        if (commit) begin
                            board     <= shadow;
                            gen_count <= gen_count + GEN_W'(1);
                            gen_done  <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                    default: begin
                        busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_life_next_gen.sv
// Scoreboard bench for life_next_gen: each accepted step pushes the expected
// committed board and generation count; a monitor pops on every gen_done.
module tb_life_next_gen;

    logic         clk;
    logic         rst_n;
    logic         step;
    logic         vblank;
    logic         load;
    logic [255:0] seed;
    logic [255:0] board;
    logic         busy;
    logic         gen_done;
    logic [15:0]  gen_count;

    typedef struct {
        logic [255:0] b;
        logic [15:0]  g;
    } exp_t;

    exp_t   exp_q[$];
    integer n_checks;
    integer n_fail;

    life_next_gen #(.ROW_SIZE(16), .COL_SIZE(16), .GEN_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (step),
        .vblank   (vblank),
        .load     (load),
        .seed     (seed),
        .board    (board),
        .busy     (busy),
        .gen_done (gen_done),
        .gen_count(gen_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] cells(input int a, input int b, input int c, input int d);
        logic [255:0] r;
        r = '0;
        r[8'(a)] = 1'b1;
        r[8'(b)] = 1'b1;
        r[8'(c)] = 1'b1;
        if (d >= 0) r[8'(d)] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [255:0] s);
        load = 1'b1;
        seed = s;
        tick();
        load = 1'b0;
    endtask

    // Step with vblank high; expected commit goes to the scoreboard, latency is checked here.
    task automatic run_step(input logic [255:0] eb, input logic [15:0] eg, input string name);
        exp_t e;
        int   k;
        e.b = eb;
        e.g = eg;
        exp_q.push_back(e);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk({name, "_busy"}, {255'd0, busy}, 256'd1);
        k = 0;
        while (!gen_done && k < 400) begin
            tick();
            k++;
        end
        chk({name, "_latency"}, 256'(k), 256'd257);
        tick();
    endtask

    // Monitor: every gen_done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && gen_done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_gen_done", 256'd1, 256'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("commit_board", board, e.b);
                chk("commit_gen_count", {240'd0, gen_count}, {240'd0, e.g});
                chk("commit_busy", {255'd0, busy}, 256'd0);
            end
        end
    end

    initial begin
        logic [255:0] blink_h;
        logic [255:0] blink_v;
        logic [255:0] block;
        logic [255:0] wrap_exp;
        logic [255:0] ones;
        n_checks = 0;
        n_fail   = 0;
        blink_h  = cells(118, 119, 120, -1);
        blink_v  = cells(103, 119, 135, -1);
        block    = cells(68, 69, 84, 85);
        ones     = '1;
`ifdef LIFE_TORUS_EN
        wrap_exp = cells(1, 17, 241, -1);
`else
        wrap_exp = cells(1, 17, 17, -1);
`endif
        rst_n  = 1'b0;
        step   = 1'b0;
        vblank = 1'b1;
        load   = 1'b0;
        seed   = '0;
        repeat (3) tick();
        chk("reset_board", board, 256'd0);
        chk("reset_busy", {255'd0, busy}, 256'd0);
        chk("reset_gen_done", {255'd0, gen_done}, 256'd0);
        chk("reset_gen_count", {240'd0, gen_count}, 256'd0);
        rst_n = 1'b1;
        tick();

        // Blinker: two generations
        do_load(blink_h);
        chk("load_board", board, blink_h);
        chk("load_gen_count", {240'd0, gen_count}, 256'd0);
        run_step(blink_v, 16'd1, "blinker1");
        run_step(blink_h, 16'd2, "blinker2");

        // Still life
        do_load(block);
        run_step(block, 16'd1, "block");

        // Blanking hold
        do_load(blink_h);
        vblank = 1'b0;
        exp_q.push_back('{b: blink_v, g: 16'd1});
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (1000) tick();
        chk("hold_board", board, blink_h);
        chk("hold_busy", {255'd0, busy}, 256'd1);
        vblank = 1'b1;
        tick();
        chk("vb_board", board, blink_v);
        chk("vb_busy", {255'd0, busy}, 256'd0);
        tick();

        // Step pulses while busy are ignored
        do_load(blink_h);
        exp_q.push_back('{b: blink_v, g: 16'd1});
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (20) tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (150) tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (120) tick();
        chk("ignore_gen_count", {240'd0, gen_count}, 256'd1);
        chk("ignore_idle", {255'd0, busy}, 256'd0);
        chk("ignore_queue", 256'(exp_q.size()), 256'd0);

        // Load mid-CALC aborts
        do_load(blink_h);
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (50) tick();
        do_load(ones);
        chk("abort_board", board, ones);
        chk("abort_busy", {255'd0, busy}, 256'd0);
        chk("abort_gen_count", {240'd0, gen_count}, 256'd0);
        chk("abort_gen_done", {255'd0, gen_done}, 256'd0);
        repeat (300) tick();
        chk("abort_board_kept", board, ones);

        // Edge behaviour
        do_load(cells(0, 1, 2, -1));
        run_step(wrap_exp, 16'd1, "edge");

        // Reset mid-CALC
        do_load(blink_h);
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (100) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_board", board, 256'd0);
        chk("rst_mid_busy", {255'd0, busy}, 256'd0);
        chk("rst_mid_gen_count", {240'd0, gen_count}, 256'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_step(256'd0, 16'd1, "after_reset");

        chk("final_queue_empty", 256'(exp_q.size()), 256'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
